// File: rtl/alu_pkg.sv
// Shared types for pipelined_alu: opcodes, FSM states and the status-flag bundle.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SRL  = 4'd3,
    ALU_SRA  = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_MUL  = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
    logic illegal;
  } alu_flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one conditional add and right shift per cycle,
// full 2*WIDTH product valid when done pulses, WIDTH cycles after start.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               busy;
  logic [WIDTH:0]     partial;

  // Upper accumulator half plus the multiplicand when the current multiplier bit is set.
  always_comb begin
    partial = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc    <= '0;
        mcand  <= a;
        mplier <= b;
        cnt    <= '0;
        busy   <= 1'b1;
      end else if (busy) begin
        acc    <= {partial, acc[WIDTH-1:1]};
        mplier <= mplier >> 1;
        cnt    <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/pipelined_alu.sv
// Handshaked ALU: single-cycle ops registered onto a valid/ready output channel.
// Define ALU_MUL_EN to enable the iterative multiplier (opcode 10); otherwise opcode 10 is illegal.
module pipelined_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_illegal
);

  localparam int unsigned SHW = $clog2(WIDTH);

  alu_state_e      state;
  alu_flags_t      flags_q;
  alu_flags_t      alu_fl;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]  add_w;
  logic [WIDTH:0]  sub_w;
  logic [SHW-1:0]  shamt;
  logic            legal;
  logic            is_mul;
  logic            accept;

  assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Single-cycle result and flags straight from the input operands.
  always_comb begin
    shamt   = in_b[SHW-1:0];
    add_w   = {1'b0, in_a} + {1'b0, in_b};
    sub_w   = {1'b0, in_a} - {1'b0, in_b};
    alu_res = '0;
    alu_fl  = '0;
    legal   = 1'b1;
    case (in_op)
      ALU_ADD: begin
        alu_res      = add_w[WIDTH-1:0];
        alu_fl.carry = add_w[WIDTH];
        alu_fl.ovf   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (alu_res[WIDTH-1] != in_a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res      = sub_w[WIDTH-1:0];
        alu_fl.carry = sub_w[WIDTH];
        alu_fl.ovf   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (alu_res[WIDTH-1] != in_a[WIDTH-1]);
      end
      ALU_SLL:  alu_res = in_a << shamt;
      ALU_SRL:  alu_res = in_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(in_a) >>> shamt);
      ALU_AND:  alu_res = in_a & in_b;
      ALU_OR:   alu_res = in_a | in_b;
      ALU_XOR:  alu_res = in_a ^ in_b;
      ALU_SLT:  alu_res = WIDTH'($signed(in_a) < $signed(in_b));
      ALU_SLTU: alu_res = WIDTH'(in_a < in_b);
      default:  legal   = 1'b0;
    endcase
    if (legal) begin
      alu_fl.zero = (alu_res == '0);
      alu_fl.neg  = alu_res[WIDTH-1];
    end else begin
      alu_res = '0;
      alu_fl  = '0;
      alu_fl.illegal = 1'b1;
    end
  end

`ifdef ALU_MUL_EN
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  alu_flags_t         mul_fl;

  assign is_mul = (in_op == ALU_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .a       (in_a),
    .b       (in_b),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    mul_fl      = '0;
    mul_fl.zero = (mul_prod[WIDTH-1:0] == '0);
    mul_fl.neg  = mul_prod[WIDTH-1];
    mul_fl.ovf  = |mul_prod[2*WIDTH-1:WIDTH];
  end
`else
  assign is_mul = 1'b0;
`endif

  // Control FSM; a consume and a new accept may land on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      flags_q    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if ((state == ST_DONE) && out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
          if (accept) begin
            if (is_mul) begin
              state     <= ST_BUSY;
              out_valid <= 1'b0;
            end else begin
              state      <= ST_DONE;
              out_valid  <= 1'b1;
              out_result <= alu_res;
              flags_q    <= alu_fl;
            end
          end
        end
        ST_BUSY: begin
`ifdef ALU_MUL_EN
          if (mul_done) begin
            state      <= ST_DONE;
            out_valid  <= 1'b1;
            out_result <= mul_prod[WIDTH-1:0];
            flags_q    <= mul_fl;
          end
`else
          state <= ST_IDLE;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_zero    = flags_q.zero;
  assign out_neg     = flags_q.neg;
  assign out_carry   = flags_q.carry;
  assign out_ovf     = flags_q.ovf;
  assign out_illegal = flags_q.illegal;

endmodule
